// File: rtl/ov7670_sccb_cfg_pkg.sv
// Shared definitions for the OV7670 SCCB configuration engine: state encoding,
// table delay marker, default write ID and the ROM entry layout.
package ov7670_sccb_cfg_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_TX    = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;
  localparam logic [2:0] ST_DELAY = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  localparam logic [7:0] DELAY_MARKER   = 8'hFF;
  localparam logic [7:0] DEV_ID_DEFAULT = 8'h42;

  typedef struct packed {
    logic [7:0] sub_addr;
    logic [7:0] data;
  } cfg_entry_t;

  // Counter width for a maximum value, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// OV7670 register table: combinational address, registered {sub_addr, data}.
module ov7670_cfg_rom
  import ov7670_sccb_cfg_pkg::*;
#(
  parameter  int unsigned REG_NUM = 166,
  localparam int unsigned AW      = clog2_min1(REG_NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  output cfg_entry_t    data_q
);

  cfg_entry_t data_d;

  always_comb begin
    data_d = cfg_entry_t'(16'h1101);
    case (32'(addr))
      0:  data_d = cfg_entry_t'(16'h1280);  // COM7 soft reset
      1:  data_d = cfg_entry_t'({DELAY_MARKER, 8'h00});  // settle after reset
      2:  data_d = cfg_entry_t'(16'h1101);
      3:  data_d = cfg_entry_t'(16'h1204);
      4:  data_d = cfg_entry_t'(16'h0C00);
      5:  data_d = cfg_entry_t'(16'h3E00);
      6:  data_d = cfg_entry_t'(16'h8C00);
      7:  data_d = cfg_entry_t'(16'h0400);
      8:  data_d = cfg_entry_t'(16'h4010);
      9:  data_d = cfg_entry_t'(16'h3A04);
      10: data_d = cfg_entry_t'(16'h1438);
      11: data_d = cfg_entry_t'(16'h4FB3);
      12: data_d = cfg_entry_t'(16'h50B3);
      13: data_d = cfg_entry_t'(16'h5100);
      14: data_d = cfg_entry_t'(16'h523D);
      15: data_d = cfg_entry_t'(16'h53A7);
      16: data_d = cfg_entry_t'(16'h54E4);
      17: data_d = cfg_entry_t'(16'h589E);
      18: data_d = cfg_entry_t'(16'h3DC0);
      19: data_d = cfg_entry_t'(16'h1714);
      20: data_d = cfg_entry_t'(16'h1802);
      21: data_d = cfg_entry_t'(16'h3280);
      22: data_d = cfg_entry_t'(16'h1903);
      23: data_d = cfg_entry_t'(16'h1A7B);
      24: data_d = cfg_entry_t'(16'h030A);
      // Unlisted slots rewrite CLKRC, which is idempotent.
      default: data_d = cfg_entry_t'(16'h1101);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

endmodule

// File: rtl/ov7670_sccb_cfg.sv
// Walks the OV7670 register table after a start_init edge, issuing 3-phase
// SCCB writes (ID, sub-address, data) with open-drain SDA.
module ov7670_sccb_cfg
  import ov7670_sccb_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 100,
  parameter int unsigned REG_NUM      = 166,
  parameter int unsigned GAP_CYCLES   = 400,
  parameter int unsigned DELAY_CYCLES = 40000,
  parameter logic [7:0]  DEV_ID       = DEV_ID_DEFAULT
) (
  input  logic S_CLK,
  input  logic RST_N,
  input  logic start_init,
  output logic init_done,
  output logic busy,
  output logic SCCB_SCL,
  inout  wire  SCCB_SDA
);

  localparam int unsigned DIV_W    = clog2_min1(CLK_DIV);
  localparam int unsigned IDX_W    = clog2_min1(REG_NUM);
  localparam int unsigned WAIT_MAX = (GAP_CYCLES > DELAY_CYCLES) ? GAP_CYCLES : DELAY_CYCLES;
  localparam int unsigned WAIT_W   = clog2_min1(WAIT_MAX);

  logic [2:0]        sync_q, sync_d;
  logic [ST_W-1:0]   state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [3:0]        bit_q, bit_d;
  logic [1:0]        ph_q, ph_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              scl_q, scl_d;
  logic              sda_oe_q, sda_oe_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;
  logic              start_rise_c, qtick_c, last_idx_c;
  logic [7:0]        tx_byte_c;
  cfg_entry_t        rom_q;

  // Address is the next index so the entry is ready in the first LOAD cycle.
  ov7670_cfg_rom #(.REG_NUM(REG_NUM)) u_rom (
    .clk   (S_CLK),
    .rst_n (RST_N),
    .addr  (idx_d),
    .data_q(rom_q)
  );

  always_comb begin
    sync_d       = {sync_q[1:0], start_init};
    state_d      = state_q;
    div_d        = div_q;
    qtr_d        = qtr_q;
    bit_d        = bit_q;
    ph_d         = ph_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    init_done_d  = init_done_q;
    busy_d       = busy_q;
    scl_d        = 1'b1;
    sda_oe_d     = 1'b0;
    tx_byte_c    = DEV_ID;
    start_rise_c = sync_q[1] & ~sync_q[2];
    qtick_c      = (div_q == DIV_W'(CLK_DIV - 1));
    last_idx_c   = (idx_q == IDX_W'(REG_NUM - 1));

    if (state_q == ST_START || state_q == ST_TX || state_q == ST_STOP) begin
      div_d = qtick_c ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_rise_c) begin
          state_d     = ST_LOAD;
          idx_d       = '0;
          init_done_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_LOAD: begin
        div_d   = '0;
        qtr_d   = '0;
        bit_d   = '0;
        ph_d    = '0;
        wait_d  = '0;
        state_d = (rom_q.sub_addr == DELAY_MARKER) ? ST_DELAY : ST_START;
      end
      ST_START: begin
        if (qtick_c) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            qtr_d   = '0;
            state_d = ST_TX;
          end
        end
      end
      ST_TX: begin
        if (qtick_c) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) begin
              bit_d = '0;
              ph_d  = ph_q + 2'd1;
              if (ph_q == 2'd2) begin
                ph_d    = '0;
                state_d = ST_STOP;
              end
            end
          end
        end
      end
      ST_STOP: begin
        if (qtick_c) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            qtr_d   = '0;
            wait_d  = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP, ST_DELAY: begin
        wait_d = wait_q + WAIT_W'(1);
        if ((state_q == ST_GAP   && wait_q == WAIT_W'(GAP_CYCLES - 1)) ||
            (state_q == ST_DELAY && wait_q == WAIT_W'(DELAY_CYCLES - 1))) begin
          wait_d  = '0;
          state_d = last_idx_c ? ST_DONE : ST_LOAD;
          idx_d   = last_idx_c ? idx_q : idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        init_done_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (ph_d)
      2'd1:    tx_byte_c = rom_q.sub_addr;
      2'd2:    tx_byte_c = rom_q.data;
      default: tx_byte_c = DEV_ID;
    endcase

    // Line levels follow the next state so they register alongside it.
    case (state_d)
      ST_START: begin
        scl_d    = (qtr_d != 2'd2);
        sda_oe_d = (qtr_d != 2'd0);
      end
      ST_TX: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = (bit_d != 4'd8) && !tx_byte_c[3'(4'd7 - bit_d)];
      end
      ST_STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = (qtr_d != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q      <= '0;
      state_q     <= ST_IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      ph_q        <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      ph_q        <= ph_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      scl_q       <= scl_d;
      sda_oe_q    <= sda_oe_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  assign SCCB_SCL  = scl_q;
  assign SCCB_SDA  = sda_oe_q ? 1'b0 : 1'bz;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ov7670_sccb_cfg.sv
// Scoreboard bench: a table model predicts the SCCB byte stream, a bus monitor
// decodes SCL/SDA into bytes and checks bit timing.
module tb_ov7670_sccb_cfg;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned REG_NUM   = 3;
  localparam int unsigned GAP       = 20;
  localparam int unsigned DLY       = 300;
  localparam int unsigned HALF      = 2 * CLK_DIV;
  localparam int          RUN_BOUND = 5000;

  logic clk = 1'b0, rst_n = 1'b0, start_init = 1'b0;
  logic init_done, busy, scl;
  wire  sda;

  pullup pu_sda (sda);

  ov7670_sccb_cfg #(
    .CLK_DIV(CLK_DIV), .REG_NUM(REG_NUM), .GAP_CYCLES(GAP),
    .DELAY_CYCLES(DLY), .DEV_ID(8'h42)
  ) dut (
    .S_CLK(clk), .RST_N(rst_n), .start_init(start_init),
    .init_done(init_done), .busy(busy), .SCCB_SCL(scl), .SCCB_SDA(sda)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [15:0] table_m [REG_NUM] = '{16'h1280, 16'hFF00, 16'h1101};
  logic [7:0]  exp_q [$];

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: each non-marker entry becomes ID, sub-address, data.
  function automatic void push_run();
    for (int i = 0; i < int'(REG_NUM); i++) begin
      logic [15:0] e;
      e = table_m[i];
      if (e[15:8] != 8'hFF) begin
        exp_q.push_back(8'h42);
        exp_q.push_back(e[15:8]);
        exp_q.push_back(e[7:0]);
      end
    end
  endfunction

  int cyc = 0, frames = 0, frame_bytes = 0, last_gap = 0, stop_cyc = 0, bitn = 0, len = 0;
  bit in_frame = 0, rise_inf = 0, fall_inf = 0;
  logic scl_p = 1'b1, sda_p = 1'b1;
  logic [8:0] sh = '0;

  // Bus monitor: START/STOP detection, byte decode at SCL rise, period checks.
  always @(negedge clk) begin
    logic s, d;
    logic [7:0] got, e;
    s = scl;
    d = (sda === 1'b0) ? 1'b0 : 1'b1;
    cyc++;
    if (!rst_n) begin
      in_frame = 0; rise_inf = 0; fall_inf = 0; bitn = 0; len = 0;
    end else begin
      if (scl_p && s && sda_p && !d) begin
        in_frame = 1; bitn = 0; frame_bytes = 0; frames++;
        last_gap = cyc - stop_cyc;
      end else if (scl_p && s && !sda_p && d && in_frame) begin
        in_frame = 0; rise_inf = 0; stop_cyc = cyc;
        chk("bytes_per_frame", frame_bytes, 3);
      end else if (in_frame && scl_p && s) begin
        chk("sda_stable_scl_high", int'(d), int'(sda_p));
      end
      if (!scl_p && s) begin
        if (fall_inf) chk("scl_low_len", len, int'(HALF));
        if (in_frame) begin
          sh = {sh[7:0], d};
          bitn++;
          if (bitn == 9) begin
            bitn = 0;
            frame_bytes++;
            got = sh[8:1];
            chk("sb_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("sb_byte", int'(got), int'(e));
            end
            chk("ack_bit_high_nack", int'(sh[0]), 1);
          end
        end
        rise_inf = in_frame;
        len = 1;
      end else if (scl_p && !s) begin
        chk("scl_fall_in_frame", int'(in_frame), 1);
        if (rise_inf) chk("scl_high_len", len, int'(HALF));
        fall_inf = in_frame;
        len = 1;
      end else begin
        len++;
      end
    end
    scl_p = s;
    sda_p = d;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: pulse start_init; mode 1: raise and leave high. reedge_at>=0 re-pulses mid-run.
  task automatic run(input string tag, input int mode, input int reedge_at);
    int f0, n, idone_bad;
    bit done, seen_busy;
    f0 = frames;
    push_run();
    @(negedge clk);
    start_init = 1'b1;
    if (mode == 0) begin
      wait_cycles(3);
      start_init = 1'b0;
    end
    done = 0; seen_busy = 0; idone_bad = 0; n = 0;
    while (!done && n < RUN_BOUND) begin
      @(negedge clk);
      n++;
      if (reedge_at >= 0) begin
        if (n == reedge_at)     start_init = 1'b1;
        if (n == reedge_at + 6) start_init = 1'b0;
      end
      if (busy) begin
        seen_busy = 1;
        if (init_done) idone_bad++;
      end else if (seen_busy) begin
        done = 1;
        chk({tag, "_init_done"}, int'(init_done), 1);
      end
    end
    chk({tag, "_finished"}, int'(done), 1);
    chk({tag, "_frames"}, frames - f0, 2);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
    chk({tag, "_init_done_low_while_busy"}, idone_bad, 0);
    chk({tag, "_delay_gap"}, int'(last_gap >= int'(DLY) &&
        last_gap < int'(DLY + 2 * GAP + 8 * CLK_DIV + 16)), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, busy_hits, k;
    wait_cycles(3);
    #1;
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda_released", int'(sda === 1'b0 ? 1'b0 : 1'b1), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_init_done", int'(init_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(5 + int'($urandom_range(0, 20)));
    chk("idle_scl", int'(scl), 1);
    chk("idle_busy", int'(busy), 0);

    run("run1", 0, -1);

    // Second edge mid-run must be ignored, and no run may follow it.
    f0 = frames;
    run("reedge", 0, int'($urandom_range(200, 800)));
    wait_cycles(600);
    chk("reedge_no_restart_frames", frames - f0, 2);
    chk("reedge_idle_busy", int'(busy), 0);

    // Reset during the sub-address byte of the first write.
    f0 = frames;
    push_run();
    @(negedge clk);
    start_init = 1'b1;
    wait_cycles(3);
    start_init = 1'b0;
    k = 0;
    while (!(frames > f0 && frame_bytes == 1) && k < RUN_BOUND) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_reached_phase2", int'(k < RUN_BOUND), 1);
    wait_cycles(int'($urandom_range(5, 100)));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_scl", int'(scl), 1);
    chk("rst_mid_sda_released", int'(sda === 1'b0 ? 1'b0 : 1'b1), 1);
    chk("rst_mid_busy", int'(busy), 0);
    exp_q.delete();
    wait_cycles(5);
    chk("rst_mid_init_done", int'(init_done), 0);
    rst_n = 1'b1;
    wait_cycles(10);
    run("after_rst", 0, -1);

    // Level held high: exactly one run over ten run lengths.
    f0 = frames;
    run("held", 1, -1);
    busy_hits = 0;
    for (int i = 0; i < 13000; i++) begin
      @(negedge clk);
      if (busy) busy_hits++;
    end
    chk("held_no_rerun_busy", busy_hits, 0);
    chk("held_frames", frames - f0, 2);
    chk("held_init_done_stays", int'(init_done), 1);
    start_init = 1'b0;
    wait_cycles(10);
    run("reraise", 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_sccb_cfg.md
OV7670_SCCB_CFG -- requirements
Module: ov7670_sccb_cfg

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100, S_CLK cycles per SCL quarter-period (40 MHz S_CLK -> 100 kHz SCL).
REQ-002 SHALL have parameter REG_NUM, default 166, number of entries in the configuration table.
REQ-003 SHALL have parameter GAP_CYCLES, default 400, idle S_CLK cycles between consecutive SCCB writes.
REQ-004 SHALL have parameter DELAY_CYCLES, default 40000, wait length for a table delay entry.
REQ-005 SHALL have parameter DEV_ID, default 8'h42, SCCB write ID.
REQ-006 SHALL provide ports: S_CLK  in  1  system clock; RST_N  in  1  asynchronous active-low reset.
REQ-007 SHALL provide ports: start_init  in  1  level; a rising edge starts a configuration run.
REQ-008 SHALL provide ports: init_done  out  1  high after the last entry is written; cleared on the next run start.
REQ-009 SHALL provide ports: busy  out  1  high while a run is in progress.
REQ-010 SHALL provide ports: SCCB_SCL  out  1  SCCB clock; SCCB_SDA  inout  1  driven 0 or Z, with an external pull-up.

Function
REQ-011 SHALL use these states: IDLE, LOAD, START, TX, STOP, GAP, DELAY, DONE.
REQ-012 IDLE->LOAD on a rising edge of the 2-flop-synchronised start_init; index=0, init_done=0, busy=1.
REQ-013 LOAD SHALL read table entry {sub_addr[7:0], data[7:0]} at index with 1-cycle latency; sub_addr==8'hFF -> DELAY, else -> START.
REQ-014 Bit timing SHALL be 4 quarters of CLK_DIV cycles: q0 SCL low and SDA updated; q1/q2 SCL high; q3 SCL low.
REQ-015 START SHALL hold SDA released and SCL high for 1 quarter, pull SDA low for 1 quarter with SCL high, then drive SCL low.
REQ-016 TX SHALL send 3 phases (DEV_ID, sub_addr, data), each 8 bits MSB-first plus a 9th don't-care bit with SDA released; ACK is not sampled.
REQ-017 STOP SHALL drive SDA low with SCL low, raise SCL, then release SDA one quarter later.
REQ-018 GAP SHALL wait GAP_CYCLES; then index+1, and -> DONE if index==REG_NUM-1, else -> LOAD.
REQ-019 DELAY SHALL wait DELAY_CYCLES with SCL high and SDA released, then advance the index as in GAP.
REQ-020 DONE SHALL set init_done=1, busy=0, and -> IDLE; init_done SHALL stay 1 until the next run start.
REQ-021 A start_init edge while busy SHALL be ignored; start_init held high after DONE SHALL NOT restart; a new edge SHALL be required.
REQ-022 When idle, SCL SHALL be 1 and SDA SHALL be released (Z).
REQ-023 Counters SHALL be sized $clog2 of their maximum; the index SHALL NOT wrap past REG_NUM-1.

Reset
REQ-024 On RST_N low, state=IDLE, SCCB_SCL=1, SDA released, init_done=0, busy=0, index=0, all counters 0.
REQ-025 A reset mid-transaction SHALL abort immediately with no STOP; the next run SHALL restart from index 0.

Structure
REQ-026 The shared package SHALL hold the state encoding, the 8'hFF delay marker, and the default DEV_ID.
REQ-027 The table SHALL be the sub-module ov7670_cfg_rom (combinational-address, registered-data case ROM, REG_NUM entries); entry 0 SHALL be {8'h12, 8'h80} (soft reset), and entry 1 SHALL be the delay marker.
REQ-028 The SCL quarter-tick divider SHALL be inside ov7670_sccb_cfg.

Verification
REQ-029 Bench: CLK_DIV=4, REG_NUM=3, ROM {12,80},{FF,xx},{11,01}; start_init pulse -> SDA bytes 42,12,80 observed at SCL rising edges; DELAY_CYCLES gap with no SCL toggles; then 42,11,01; init_done=1.
REQ-030 Bench: timing check -> SDA changes only while SCL low, except START/STOP; SCL high and low each 2*CLK_DIV cycles.
REQ-031 Bench: a second start_init edge mid-run -> ignored, exactly 2 SCCB transactions, busy held.
REQ-032 Bench: RST_N asserted during the second phase -> SCL=1, SDA=Z, busy=0 in the same cycle; after release and a new edge, the run restarts with byte 42,12.
REQ-033 Bench: start_init held high for 10 runs' duration -> exactly one run; drop then raise -> second run, with init_done low from LOAD until DONE.
REQ-034 Bench: slave ACK line forced high (NACK) -> the sequence still completes unchanged.
